// File: rtl/sim_run_ctrl.sv
// Bench run sequencer: holds DUT reset, waits a settle interval, then enables
// the test and counts run cycles until done or watchdog timeout.
module sim_run_ctrl #(
    parameter int C_RST_CYCLES     = 16,
    parameter int C_SETTLE_CYCLES  = 4,
    parameter int C_TIMEOUT_CYCLES = 100000,
    parameter int C_CNT_WIDTH      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   test_done,
    input  logic                   test_pass,
    output logic                   rst_out,
    output logic                   test_en,
    output logic [C_CNT_WIDTH-1:0] cycle_cnt,
    output logic                   sim_finished,
    output logic                   sim_pass,
    output logic                   sim_timeout
);

    // The phase counter is shared by RESET and SETTLE, so size it for the longer one.
    localparam int PH_MAX      = (C_RST_CYCLES > C_SETTLE_CYCLES) ? C_RST_CYCLES : C_SETTLE_CYCLES;
    localparam int PH_W        = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int SETTLE_LAST = (C_SETTLE_CYCLES > 0) ? C_SETTLE_CYCLES - 1 : 0;

    localparam logic [PH_W-1:0]        RST_END    = PH_W'(C_RST_CYCLES - 1);
    localparam logic [PH_W-1:0]        SETTLE_END = PH_W'(SETTLE_LAST);
    localparam logic [C_CNT_WIDTH-1:0] TO_END     = C_CNT_WIDTH'(C_TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_SETTLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t                 state, state_nxt;
    logic [PH_W-1:0]        phase_cnt, phase_nxt;
    logic                   rst_out_nxt, test_en_nxt;
    logic [C_CNT_WIDTH-1:0] cycle_cnt_nxt;
    logic                   finished_nxt, pass_nxt, timeout_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RESET;
            phase_cnt    <= '0;
            rst_out      <= 1'b1;
            test_en      <= 1'b0;
            cycle_cnt    <= '0;
            sim_finished <= 1'b0;
            sim_pass     <= 1'b0;
            sim_timeout  <= 1'b0;
        end else begin
            state        <= state_nxt;
            phase_cnt    <= phase_nxt;
            rst_out      <= rst_out_nxt;
            test_en      <= test_en_nxt;
            cycle_cnt    <= cycle_cnt_nxt;
            sim_finished <= finished_nxt;
            sim_pass     <= pass_nxt;
            sim_timeout  <= timeout_nxt;
        end
    end

    // Next-state logic computes the next value of every output register,
    // so each output changes exactly on the edge that changes the state.
    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase_cnt;
        rst_out_nxt   = rst_out;
        test_en_nxt   = test_en;
        cycle_cnt_nxt = cycle_cnt;
        finished_nxt  = sim_finished;
        pass_nxt      = sim_pass;
        timeout_nxt   = sim_timeout;

        case (state)
            ST_RESET: begin
                if (phase_cnt == RST_END) begin
                    phase_nxt   = '0;
                    rst_out_nxt = 1'b0;
                    if (C_SETTLE_CYCLES == 0) begin
                        state_nxt   = ST_RUN;
                        test_en_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_SETTLE;
                    end
                end else begin
                    phase_nxt = phase_cnt + 1'b1;
                end
            end

            ST_SETTLE: begin
                if (phase_cnt == SETTLE_END) begin
                    phase_nxt   = '0;
                    state_nxt   = ST_RUN;
                    test_en_nxt = 1'b1;
                end else begin
                    phase_nxt = phase_cnt + 1'b1;
                end
            end

            // test_done takes priority over the watchdog on the same edge.
            ST_RUN: begin
                cycle_cnt_nxt = cycle_cnt + 1'b1;
                if (test_done) begin
                    state_nxt    = ST_DONE;
                    test_en_nxt  = 1'b0;
                    finished_nxt = 1'b1;
                    pass_nxt     = test_pass;
                    timeout_nxt  = 1'b0;
                end else if (cycle_cnt == TO_END) begin
                    state_nxt    = ST_DONE;
                    test_en_nxt  = 1'b0;
                    finished_nxt = 1'b1;
                    pass_nxt     = 1'b0;
                    timeout_nxt  = 1'b1;
                end
            end

            ST_DONE: begin
                if (start) begin
                    state_nxt     = ST_RESET;
                    phase_nxt     = '0;
                    rst_out_nxt   = 1'b1;
                    test_en_nxt   = 1'b0;
                    cycle_cnt_nxt = '0;
                    finished_nxt  = 1'b0;
                    pass_nxt      = 1'b0;
                    timeout_nxt   = 1'b0;
                end
            end

            default: begin
                state_nxt = ST_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: a settle=2 instance exercises every phase,
// a settle=0 instance checks the skipped-settle timeline.
module tb_sim_run_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       test_done;
    logic       test_pass;
    logic       rst_out;
    logic       test_en;
    logic [7:0] cycle_cnt;
    logic       sim_finished;
    logic       sim_pass;
    logic       sim_timeout;

    logic       start0;
    logic       done0;
    logic       pass0;
    logic       rst_out0;
    logic       test_en0;
    logic [7:0] cycle_cnt0;
    logic       finished0;
    logic       spass0;
    logic       timeout0;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sim_run_ctrl #(
        .C_RST_CYCLES(4), .C_SETTLE_CYCLES(2), .C_TIMEOUT_CYCLES(20), .C_CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .test_done(test_done), .test_pass(test_pass),
        .rst_out(rst_out), .test_en(test_en), .cycle_cnt(cycle_cnt),
        .sim_finished(sim_finished), .sim_pass(sim_pass), .sim_timeout(sim_timeout)
    );

    sim_run_ctrl #(
        .C_RST_CYCLES(4), .C_SETTLE_CYCLES(0), .C_TIMEOUT_CYCLES(20), .C_CNT_WIDTH(8)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .test_done(done0), .test_pass(pass0),
        .rst_out(rst_out0), .test_en(test_en0), .cycle_cnt(cycle_cnt0),
        .sim_finished(finished0), .sim_pass(spass0), .sim_timeout(timeout0)
    );

    // Advance one edge and settle past it before anything is sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic s, input logic d, input logic p);
        start     = s;
        test_done = d;
        test_pass = p;
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Packed as {rst_out, test_en, finished, pass, timeout, 3'b0, cycle_cnt}.
    task automatic check_main(input string tag, input logic r, input logic en, input logic f,
                              input logic p, input logic t, input logic [7:0] c);
        check_output(tag, {rst_out, test_en, sim_finished, sim_pass, sim_timeout, 3'b000, cycle_cnt},
                     {r, en, f, p, t, 3'b000, c});
    endtask

    task automatic check_zero(input string tag, input logic r, input logic en, input logic [7:0] c);
        check_output(tag, {rst_out0, test_en0, finished0, spass0, timeout0, 3'b000, cycle_cnt0},
                     {r, en, 1'b0, 1'b0, 1'b0, 3'b000, c});
    endtask

    // Walks E1..E7 after a reset edge E0; a test_done pulse sampled at E5
    // (during SETTLE) must be ignored.
    task automatic check_timeline(input string tag, input bit with_zero);
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 4) apply_stimulus(1'b0, 1'b1, 1'b1);
            if (e == 5) apply_stimulus(1'b0, 1'b0, 1'b0);
            check_main($sformatf("%s_E%0d", tag, e), (e < 4), (e >= 6), 1'b0, 1'b0, 1'b0,
                       (e >= 7) ? 8'(e - 6) : 8'd0);
            if (with_zero)
                check_zero($sformatf("%s_s0_E%0d", tag, e), (e < 4), (e >= 4),
                           (e >= 5) ? 8'(e - 4) : 8'd0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0;
        done0  = 1'b0;
        pass0  = 1'b0;
        apply_stimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        check_main("reset_state", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_zero("reset_state_s0", 1'b1, 1'b0, 8'd0);
        check_timeline("release", 1'b1);

        // start is ignored while running
        apply_stimulus(1'b1, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_main("start_in_run", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2);

        repeat (7) tick();
        check_main("run_cnt9", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd9);
        apply_stimulus(1'b0, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_main("pass_done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd10);

        // DONE holds; done/pass toggling is ignored there
        for (int i = 0; i < 50; i++) begin
            apply_stimulus(1'b0, i[0], i[1]);
            tick();
            check_main($sformatf("hold_%0d", i), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd10);
        end

        apply_stimulus(1'b1, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_main("restart1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_timeline("tl_wd", 1'b0);
        repeat (18) tick();
        check_main("wd_cnt19", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd19);
        tick();
        check_main("watchdog", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd20);
        tick();
        check_main("watchdog_hold", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd20);

        apply_stimulus(1'b1, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_main("restart2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_timeline("tl_tie", 1'b0);
        repeat (18) tick();
        apply_stimulus(1'b0, 1'b1, 1'b1);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_main("done_beats_wd", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd20);

        apply_stimulus(1'b1, 1'b0, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_main("restart3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_timeline("tl_mid", 1'b0);
        repeat (6) tick();
        check_main("mid_cnt7", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_main("mid_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        check_zero("mid_reset_s0", 1'b1, 1'b0, 8'd0);
        check_timeline("tl_after_rst", 1'b1);

        repeat (2) tick();
        apply_stimulus(1'b0, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 1'b0, 1'b0);
        check_main("fail_done", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
